led_seq_gen: RTL and testbench



---
 rtl/led_seq_gen_pkg.sv | 58 +++++
 rtl/led_seq_gen_if.sv | 31 +++
 rtl/led_seq_gen_tick.sv | 40 ++++
 rtl/led_seq_gen.sv | 97 +++++++++
 tb/tb_led_seq_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/led_seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and pattern helpers for the LED pattern sequencer.
//   mode_e    : 2-bit pattern mode (FILL / CHASE / CONVERGE / BLINK)
//   mode_len  : number of steps in a mode's pattern for a given LED count
//   pattern   : LED vector for (mode, step, dir, LED count), LSB-aligned in a
//               MAX_LED_W-wide word; callers size-cast to their LED width.
// Build option: LED_ACTIVE_LOW_EN (handled in led_seq_gen, not here).
// -----------------------------------------------------------------------------
package led_seq_pkg;

  // Widest LED bank the pattern helper can describe.
  localparam int MAX_LED_W = 64;

  typedef enum logic [1:0] {
    MODE_FILL     = 2'd0,
    MODE_CHASE    = 2'd1,
    MODE_CONVERGE = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  // Pattern length (steps before wrapping) of each mode.
  function automatic int mode_len(input mode_e mode, input int led_w);
    int len;
    case (mode)
      MODE_FILL:     len = led_w + 1;
      MODE_CHASE:    len = led_w;
      MODE_CONVERGE: len = (led_w / 2) + 1;
      MODE_BLINK:    len = 2;
      default:       len = 2;
    endcase
    return len;
  endfunction

  // LED vector for one step; bits at and above led_w are always zero.
  function automatic logic [MAX_LED_W-1:0] pattern(input mode_e mode,
                                                   input int    step,
                                                   input logic  dir,
                                                   input int    led_w);
    logic [MAX_LED_W-1:0] pat;
    pat = {MAX_LED_W{1'b0}};
    for (int i = 0; i < MAX_LED_W; i++) begin
      if (i < led_w) begin
        case (mode)
          MODE_FILL:     pat[i] = (i >= led_w - step);
          MODE_CHASE:    pat[i] = dir ? (i == led_w - 1 - step) : (i == step);
          MODE_CONVERGE: pat[i] = (i < step) || (i >= led_w - step);
          MODE_BLINK:    pat[i] = (step == 0);
          default:       pat[i] = 1'b0;
        endcase
      end else begin
        pat[i] = 1'b0;
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/led_seq_gen_if.sv
// -----------------------------------------------------------------------------
// led_seq_gen_if
// Control/status bundle between the board switches/buttons and the sequencer.
//   mode_i  : requested mode           auto_i : auto-advance mode on wrap
//   pause_i : freeze the sequencer     dir_i  : CHASE direction
//   led     : LED drive                tick_o : step-enable pulse
//   wrap_o  : pattern wrap pulse       mode_o : active mode
// master = controller side (drives requests), slave = sequencer side.
// -----------------------------------------------------------------------------
interface led_seq_gen_if #(
  parameter int LED_W = 8
);
  logic [1:0]       mode_i;
  logic             auto_i;
  logic             pause_i;
  logic             dir_i;
  logic [LED_W-1:0] led;
  logic             tick_o;
  logic             wrap_o;
  logic [1:0]       mode_o;

  modport master (
    output mode_i, auto_i, pause_i, dir_i,
    input  led, tick_o, wrap_o, mode_o
  );

  modport slave (
    input  mode_i, auto_i, pause_i, dir_i,
    output led, tick_o, wrap_o, mode_o
  );
endinterface

// File: rtl/led_seq_gen_tick.sv
// -----------------------------------------------------------------------------
// led_seq_tick
// Step prescaler: counts 0..TICK_DIV-1 and wraps; o_tick marks the last count
// of each period. While i_pause is high the count holds and o_tick is low, so
// the remainder of a period completes exactly after release.
//   i_clk   : clock               i_rst_n : synchronous active-low reset
//   i_pause : freeze the count    o_tick  : step enable (one cycle per period)
// Parameters: TICK_DIV (cycles per step, >=1), CNT_W (2**CNT_W >= TICK_DIV).
// -----------------------------------------------------------------------------
module led_seq_tick #(
  parameter int TICK_DIV = 8388608,
  parameter int CNT_W    = 24
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pause,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));
  // Gated by pause directly so a paused cycle can never produce a step.
  assign o_tick = w_last & ~i_pause;

  // Prescaler counter: hold on pause, wrap after the last count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_pause) begin
      r_cnt <= r_cnt;
    end else if (w_last) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_gen.sv
// -----------------------------------------------------------------------------
// led_seq_gen
// Parametrised LED pattern sequencer. A prescaler tick advances a step counter
// through the active mode's pattern; the LED register loads the pattern of the
// next step on the same edge. Mode requests (or auto-advance) are taken only
// when a pattern wraps, so patterns are never cut short.
//   mclk  : system clock          rst_n : synchronous active-low reset
//   bus   : led_seq_gen_if.slave (mode_i, auto_i, pause_i, dir_i in;
//           led, tick_o, wrap_o, mode_o out)
// Parameters: LED_W (even, >=2), TICK_DIV (>=1), CNT_W (2**CNT_W >= TICK_DIV).
// Build option: define LED_ACTIVE_LOW_EN to drive led inverted (reset = ones).
// -----------------------------------------------------------------------------
module led_seq_gen
  import led_seq_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 8388608,
  parameter int CNT_W    = 24
) (
  input logic          mclk,
  input logic          rst_n,
  led_seq_gen_if.slave bus
);

  localparam int STEP_W = $clog2(LED_W + 1);

  // XOR mask applied to every pattern written to the LED register.
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_POL = {LED_W{1'b1}};
`else
  localparam logic [LED_W-1:0] LED_POL = {LED_W{1'b0}};
`endif

  logic              w_tick;
  logic [STEP_W-1:0] r_step;
  mode_e             r_mode;
  logic [LED_W-1:0]  r_led;
  logic [STEP_W-1:0] w_last_step;
  logic              w_at_last;
  logic [STEP_W-1:0] w_step_nxt;
  mode_e             w_mode_nxt;
  logic [LED_W-1:0]  w_pat;

  led_seq_tick #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .i_clk   (mclk),
    .i_rst_n (rst_n),
    .i_pause (bus.pause_i),
    .o_tick  (w_tick)
  );

  // Next step/mode and the pattern they select; only consumed on a tick.
  always_comb begin
    w_last_step = STEP_W'(mode_len(r_mode, LED_W) - 1);
    w_at_last   = (r_step == w_last_step);
    w_step_nxt  = r_step;
    w_mode_nxt  = r_mode;
    if (w_at_last) begin
      w_step_nxt = {STEP_W{1'b0}};
      if (bus.auto_i) begin
        w_mode_nxt = mode_e'(r_mode + 2'd1);
      end else begin
        w_mode_nxt = mode_e'(bus.mode_i);
      end
    end else begin
      w_step_nxt = r_step + STEP_W'(1);
      w_mode_nxt = r_mode;
    end
    // Pattern from next mode/step so led never shows a stale step.
    w_pat = LED_W'(pattern(w_mode_nxt, int'(w_step_nxt), bus.dir_i, LED_W));
  end

  // Step, mode and LED registers advance together on each tick.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_step <= {STEP_W{1'b0}};
      r_mode <= MODE_FILL;
      r_led  <= LED_POL;
    end else if (w_tick) begin
      r_step <= w_step_nxt;
      r_mode <= w_mode_nxt;
      r_led  <= w_pat ^ LED_POL;
    end else begin
      r_step <= r_step;
      r_mode <= r_mode;
      r_led  <= r_led;
    end
  end

  assign bus.led    = r_led;
  assign bus.tick_o = w_tick;
  assign bus.wrap_o = w_tick & w_at_last;
  assign bus.mode_o = r_mode;

endmodule

// File: tb/tb_led_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_led_seq_gen
// Directed bench for led_seq_gen with LED_W=8, TICK_DIV=4. Inputs change and
// outputs are sampled on the falling edge of mclk.
// -----------------------------------------------------------------------------
module tb_led_seq_gen;

  logic mclk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif

  logic [7:0] fill_exp [8]  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] chase0_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] chase1_exp [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] conv_exp [5]  = '{8'h00, 8'h81, 8'hC3, 8'hE7, 8'hFF};

  led_seq_gen_if #(.LED_W(8)) ifc ();

  led_seq_gen #(
    .LED_W    (8),
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the next tick, returns its wrap_o, then moves one
  // cycle on so led shows the new step.
  task automatic next_step(output logic wr);
    int n;
    @(negedge mclk);
    n = 1;
    while (ifc.tick_o !== 1'b1 && n < 20) begin
      @(negedge mclk);
      n++;
    end
    checks++;
    if (ifc.tick_o !== 1'b1) begin
      errors++;
      $display("FAIL step_timeout: tick_o=%b after %0d cycles, required 1", ifc.tick_o, n);
    end
    wr = ifc.wrap_o;
    @(negedge mclk);
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    ifc.mode_i = 2'd0; ifc.auto_i = 1'b0; ifc.pause_i = 1'b0; ifc.dir_i = 1'b0;
    repeat (3) @(negedge mclk);
    checks++; if (ifc.led !== (8'h00 ^ POL)) begin errors++; $display("FAIL reset_led: got %h required %h", ifc.led, 8'h00 ^ POL); end
    checks++; if (ifc.tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b required 0", ifc.tick_o); end
    checks++; if (ifc.wrap_o !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b required 0", ifc.wrap_o); end
    checks++; if (ifc.mode_o !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d required 0", ifc.mode_o); end
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (ifc.tick_o !== 1'b1 && n < 20);
    checks++; if (n !== 3) begin errors++; $display("FAIL first_tick_latency: tick seen at cycle %0d required 3", n); end
    checks++; if (ifc.wrap_o !== 1'b0) begin errors++; $display("FAIL first_tick_wrap: got %b required 0", ifc.wrap_o); end
    @(negedge mclk);
    checks++; if (ifc.led !== (8'h80 ^ POL)) begin errors++; $display("FAIL first_step_led: got %h required %h", ifc.led, 8'h80 ^ POL); end
  endtask

  // Continues FILL from step 1 through the wrap back to step 0.
  task automatic test_fill;
    logic wr;
    for (int k = 1; k < 8; k++) begin
      next_step(wr);
      checks++; if (ifc.led !== (fill_exp[k] ^ POL) || wr !== 1'b0) begin errors++; $display("FAIL fill_step%0d: led=%h wrap=%b required %h wrap=0", k + 1, ifc.led, wr, fill_exp[k] ^ POL); end
    end
    next_step(wr);
    checks++; if (ifc.led !== (8'h00 ^ POL) || wr !== 1'b1) begin errors++; $display("FAIL fill_wrap: led=%h wrap=%b required %h wrap=1", ifc.led, wr, 8'h00 ^ POL); end
    checks++; if (ifc.mode_o !== 2'd0) begin errors++; $display("FAIL fill_wrap_mode: got %0d required 0", ifc.mode_o); end
  endtask

  // Mode request mid-pattern waits for the wrap; then CHASE in both directions.
  task automatic test_mode_hold_chase;
    logic wr;
    for (int k = 0; k < 3; k++) next_step(wr);
    ifc.mode_i = 2'd1;
    for (int k = 3; k < 8; k++) begin
      next_step(wr);
      checks++; if (ifc.led !== (fill_exp[k] ^ POL) || ifc.mode_o !== 2'd0) begin errors++; $display("FAIL hold_fill%0d: led=%h mode=%0d required %h mode=0", k + 1, ifc.led, ifc.mode_o, fill_exp[k] ^ POL); end
    end
    next_step(wr);
    checks++; if (ifc.led !== (chase0_exp[0] ^ POL) || ifc.mode_o !== 2'd1 || wr !== 1'b1) begin errors++; $display("FAIL chase_entry: led=%h mode=%0d wrap=%b required %h mode=1 wrap=1", ifc.led, ifc.mode_o, wr, chase0_exp[0] ^ POL); end
    for (int k = 1; k < 8; k++) begin
      next_step(wr);
      checks++; if (ifc.led !== (chase0_exp[k] ^ POL)) begin errors++; $display("FAIL chase_up%0d: got %h required %h", k, ifc.led, chase0_exp[k] ^ POL); end
    end
    ifc.dir_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      next_step(wr);
      checks++; if (ifc.led !== (chase1_exp[k] ^ POL) || ifc.mode_o !== 2'd1) begin errors++; $display("FAIL chase_down%0d: led=%h mode=%0d required %h mode=1", k, ifc.led, ifc.mode_o, chase1_exp[k] ^ POL); end
    end
  endtask

  // Auto mode: CHASE -> CONVERGE -> BLINK -> FILL -> CHASE at successive wraps.
  task automatic test_auto;
    logic wr;
    ifc.auto_i = 1'b1;
    ifc.dir_i  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_step(wr);
      checks++; if (ifc.led !== (conv_exp[k] ^ POL) || ifc.mode_o !== 2'd2) begin errors++; $display("FAIL conv%0d: led=%h mode=%0d required %h mode=2", k, ifc.led, ifc.mode_o, conv_exp[k] ^ POL); end
    end
    next_step(wr);
    checks++; if (ifc.led !== (8'hFF ^ POL) || ifc.mode_o !== 2'd3 || wr !== 1'b1) begin errors++; $display("FAIL blink0: led=%h mode=%0d wrap=%b required %h mode=3 wrap=1", ifc.led, ifc.mode_o, wr, 8'hFF ^ POL); end
    next_step(wr);
    checks++; if (ifc.led !== (8'h00 ^ POL) || wr !== 1'b0) begin errors++; $display("FAIL blink1: led=%h wrap=%b required %h wrap=0", ifc.led, wr, 8'h00 ^ POL); end
    next_step(wr);
    checks++; if (ifc.led !== (8'h00 ^ POL) || ifc.mode_o !== 2'd0 || wr !== 1'b1) begin errors++; $display("FAIL auto_to_fill: led=%h mode=%0d wrap=%b required %h mode=0 wrap=1", ifc.led, ifc.mode_o, wr, 8'h00 ^ POL); end
    for (int k = 0; k < 8; k++) next_step(wr);
    checks++; if (ifc.led !== (8'hFF ^ POL) || ifc.mode_o !== 2'd0) begin errors++; $display("FAIL auto_fill_end: led=%h mode=%0d required %h mode=0", ifc.led, ifc.mode_o, 8'hFF ^ POL); end
    next_step(wr);
    checks++; if (ifc.led !== (8'h01 ^ POL) || ifc.mode_o !== 2'd1 || wr !== 1'b1) begin errors++; $display("FAIL auto_to_chase: led=%h mode=%0d wrap=%b required %h mode=1 wrap=1", ifc.led, ifc.mode_o, wr, 8'h01 ^ POL); end
    ifc.auto_i = 1'b0;
  endtask

  // Pause with the prescaler at 2: nothing moves; one cycle after release a tick.
  task automatic test_pause;
    @(negedge mclk);
    @(negedge mclk);
    ifc.pause_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge mclk);
      checks++; if (ifc.led !== (8'h01 ^ POL) || ifc.tick_o !== 1'b0 || ifc.wrap_o !== 1'b0) begin errors++; $display("FAIL pause_hold%0d: led=%h tick=%b wrap=%b required %h tick=0 wrap=0", k, ifc.led, ifc.tick_o, ifc.wrap_o, 8'h01 ^ POL); end
    end
    ifc.pause_i = 1'b0;
    @(negedge mclk);
    checks++; if (ifc.tick_o !== 1'b1) begin errors++; $display("FAIL pause_release_tick: got %b required 1", ifc.tick_o); end
    @(negedge mclk);
    checks++; if (ifc.led !== (8'h02 ^ POL) || ifc.tick_o !== 1'b0) begin errors++; $display("FAIL pause_after_step: led=%h tick=%b required %h tick=0", ifc.led, ifc.tick_o, 8'h02 ^ POL); end
  endtask

  // One-cycle reset at CHASE step 5 restarts mode, step and prescaler.
  task automatic test_reset_mid;
    logic wr;
    int   n;
    for (int k = 0; k < 4; k++) next_step(wr);
    checks++; if (ifc.led !== (8'h20 ^ POL)) begin errors++; $display("FAIL mid_pre_reset: got %h required %h", ifc.led, 8'h20 ^ POL); end
    rst_n = 1'b0;
    @(negedge mclk);
    rst_n = 1'b1;
    checks++; if (ifc.led !== (8'h00 ^ POL) || ifc.mode_o !== 2'd0 || ifc.tick_o !== 1'b0) begin errors++; $display("FAIL mid_reset: led=%h mode=%0d tick=%b required %h mode=0 tick=0", ifc.led, ifc.mode_o, ifc.tick_o, 8'h00 ^ POL); end
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (ifc.tick_o !== 1'b1 && n < 20);
    checks++; if (n !== 3) begin errors++; $display("FAIL mid_reset_latency: tick seen at cycle %0d required 3", n); end
    @(negedge mclk);
    checks++; if (ifc.led !== (8'h80 ^ POL) || ifc.mode_o !== 2'd0) begin errors++; $display("FAIL mid_reset_step1: led=%h mode=%0d required %h mode=0", ifc.led, ifc.mode_o, 8'h80 ^ POL); end
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.mode_i = 2'd0; ifc.auto_i = 1'b0; ifc.pause_i = 1'b0; ifc.dir_i = 1'b0;
    test_reset();
    test_fill();
    test_mode_hold_chase();
    test_auto();
    test_pause();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
